// File: rtl/apb_fsm_controller_if.sv
// AHB-side address/data signals and APB bus of the AHB-to-APB sequencer; Pready exists only with APB_PREADY_EN.
// slave modport belongs to the controller, master modport to the surrounding bridge/peripheral model.
interface apb_fsm_controller_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              valid;
  logic              Hwrite;
  logic [ADDR_W-1:0] Haddr;
  logic [DATA_W-1:0] Hwdata;
  logic [2:0]        tempselx;
  logic [DATA_W-1:0] Prdata;
`ifdef APB_PREADY_EN
  logic              Pready;
`endif
  logic [2:0]        Pselx;
  logic              Penable;
  logic              Pwrite;
  logic [ADDR_W-1:0] Paddr;
  logic [DATA_W-1:0] Pwdata;
  logic              Hreadyout;
  logic [DATA_W-1:0] Hrdata;

  modport slave (
`ifdef APB_PREADY_EN
    input  Pready,
`endif
    input  valid, Hwrite, Haddr, Hwdata, tempselx, Prdata,
    output Pselx, Penable, Pwrite, Paddr, Pwdata, Hreadyout, Hrdata
  );

  modport master (
`ifdef APB_PREADY_EN
    output Pready,
`endif
    output valid, Hwrite, Haddr, Hwdata, tempselx, Prdata,
    input  Pselx, Penable, Pwrite, Paddr, Pwdata, Hreadyout, Hrdata
  );
endinterface

// File: rtl/apb_fsm_controller.sv
// AHB-to-APB sequencer: each accepted AHB transfer becomes an APB SETUP+ENABLE pair, one transfer buffered (APB_PREADY_EN adds Pready wait states).
// Read latency 2 cycles; master stalled via Hreadyout while a buffered transfer drains or a read is in SETUP.
module apb_fsm_controller #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input logic                  Hclk,
  input logic                  Hreset,
  apb_fsm_controller_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE, WWAIT, READ, RENABLE, WRITE, WRITEP, WENABLE, WENABLEP
  } state_t;

  typedef struct packed {
    logic [2:0]        sel;
    logic              en;
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              hready;
  } apb_out_t;

  localparam apb_out_t OUT_RST = '{sel: 3'b000, en: 1'b0, wr: 1'b0,
                                   addr: '0, wdata: '0, hready: 1'b1};

  state_t            state, state_nxt;
  apb_out_t          out_q, out_d;
  logic [ADDR_W-1:0] pend_addr, pend_addr_nxt;
  logic [2:0]        pend_sel, pend_sel_nxt;
  logic              pend_wr, pend_wr_nxt;
  logic              pready;

`ifdef APB_PREADY_EN
  assign pready = bus.Pready;
`else
  assign pready = 1'b1;
`endif

  always_ff @(posedge Hclk or posedge Hreset) begin
    if (Hreset) begin
      state     <= IDLE;
      out_q     <= OUT_RST;
      pend_addr <= '0;
      pend_sel  <= '0;
      pend_wr   <= 1'b0;
    end else begin
      state     <= state_nxt;
      out_q     <= out_d;
      pend_addr <= pend_addr_nxt;
      pend_sel  <= pend_sel_nxt;
      pend_wr   <= pend_wr_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    out_d         = out_q;
    pend_addr_nxt = pend_addr;
    pend_sel_nxt  = pend_sel;
    pend_wr_nxt   = pend_wr;

    case (state)
      // ENABLE states only move on once the peripheral is ready
      IDLE, RENABLE, WENABLE: begin
        if (state == IDLE || pready) begin
          out_d.en = 1'b0;
          if (bus.valid && bus.Hwrite) begin
            state_nxt     = WWAIT;
            pend_addr_nxt = bus.Haddr;
            pend_sel_nxt  = bus.tempselx;
            pend_wr_nxt   = 1'b1;
            out_d.sel     = 3'b000;
            out_d.hready  = 1'b1;
          end else if (bus.valid) begin
            state_nxt    = READ;
            out_d.addr   = bus.Haddr;
            out_d.sel    = bus.tempselx;
            out_d.wr     = 1'b0;
            out_d.hready = 1'b0;
          end else begin
            state_nxt    = IDLE;
            out_d.sel    = 3'b000;
            out_d.hready = 1'b1;
          end
        end
      end

      // write data arrives now; a new address may be buffered in the same cycle
      WWAIT: begin
        out_d.addr  = pend_addr;
        out_d.sel   = pend_sel;
        out_d.wdata = bus.Hwdata;
        out_d.wr    = 1'b1;
        out_d.en    = 1'b0;
        if (bus.valid) begin
          state_nxt     = WRITEP;
          out_d.hready  = 1'b0;
          pend_addr_nxt = bus.Haddr;
          pend_sel_nxt  = bus.tempselx;
          pend_wr_nxt   = bus.Hwrite;
        end else begin
          state_nxt    = WRITE;
          out_d.hready = 1'b1;
        end
      end

      WRITE: begin
        out_d.en = 1'b1;
        if (bus.valid) begin
          state_nxt     = WENABLEP;
          out_d.hready  = 1'b0;
          pend_addr_nxt = bus.Haddr;
          pend_sel_nxt  = bus.tempselx;
          pend_wr_nxt   = bus.Hwrite;
        end else begin
          state_nxt    = WENABLE;
          out_d.hready = 1'b1;
        end
      end

      WRITEP: begin
        state_nxt    = WENABLEP;
        out_d.en     = 1'b1;
        out_d.hready = 1'b0;
      end

      READ: begin
        state_nxt    = RENABLE;
        out_d.en     = 1'b1;
        out_d.hready = 1'b1;
      end

      WENABLEP: begin
        if (pready) begin
          out_d.addr = pend_addr;
          out_d.sel  = pend_sel;
          out_d.en   = 1'b0;
          if (pend_wr) begin
            state_nxt    = WRITE;
            out_d.wdata  = bus.Hwdata;
            out_d.wr     = 1'b1;
            out_d.hready = 1'b1;
          end else begin
            state_nxt    = READ;
            out_d.wr     = 1'b0;
            out_d.hready = 1'b0;
          end
        end
      end

      default: begin
        state_nxt = IDLE;
        out_d     = OUT_RST;
      end
    endcase
  end

  assign bus.Pselx   = out_q.sel;
  assign bus.Penable = out_q.en;
  assign bus.Pwrite  = out_q.wr;
  assign bus.Paddr   = out_q.addr;
  assign bus.Pwdata  = out_q.wdata;
  assign bus.Hrdata  = (state == RENABLE) ? bus.Prdata : '0;

`ifdef APB_PREADY_EN
  assign bus.Hreadyout = out_q.hready &
                         (pready || !(state == RENABLE || state == WENABLE));
`else
  assign bus.Hreadyout = out_q.hready;
`endif

endmodule
